conv_inst_seq: RTL and testbench

CONV_INST_SEQ -- requirements
Module: conv_inst_seq

---
 rtl/conv_inst_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_inst_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_inst_seq.sv
// conv_inst_seq: instruction sequencer for one convolution pass on the
// systolic core. For each kernel tap (kij) it resets the core, loads weights
// through L0, streams activations, executes, drains, and reads the output
// FIFO into psum memory. It then runs an accumulation phase that sums the
// len_kij partial sums for every output pixel and applies relu.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   reset      - synchronous, active-high
//   start      - starts a pass when sampled high while idle
//   mode       - 0 normal (4-bit), 1 SIMD (2-bit); latched at start
//   inst[34:0] - registered instruction bus to the core
//   core_reset - registered per-kij / per-output reset pulse to the core
//   busy       - high while a pass is in progress
//   done       - one-cycle pulse together with the final relu
//   kij_idx    - kernel tap currently being sequenced
module conv_inst_seq #(
    parameter int unsigned col           = 8,
    parameter int unsigned len_nij       = 36,
    parameter int unsigned len_kij       = 9,
    parameter int unsigned len_onij      = 16,
    parameter int unsigned o_ni_dim      = 4,
    parameter int unsigned a_pad_ni_dim  = 6,
    parameter int unsigned ki_dim        = 3,
    parameter int unsigned w_addr_start  = 1024,
    parameter int unsigned w_addr_offset = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    output logic [34:0] inst,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_W_L0, S_W_LD, S_GAP,
        S_A_L0, S_EXEC, S_DRAIN, S_OF_RD, S_ACC
    } state_t;

    // CEN/WEN of both memories high, everything else low.
    localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

    localparam logic [15:0] RST_LAST  = 16'd10;
    localparam logic [15:0] GAP_LAST  = 16'd10;
    localparam logic [15:0] NIJ       = 16'(len_nij);
    localparam logic [15:0] NIJ_LAST  = 16'(len_nij - 1);
    localparam logic [15:0] KIJ_CYC   = 16'(len_kij);
    localparam logic [15:0] ACC_LAST  = 16'(len_kij + 2);
    localparam logic [15:0] ONIJ_LAST = 16'(len_onij - 1);
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] o;
    logic [3:0]  kij;
    logic        mode_r;
    logic [15:0] wr;

    logic [34:0] inst_d;
    logic        core_reset_d;
    logic        done_d;
    logic [31:0] j;

    assign wr = mode_r ? 16'(2 * col) : 16'(col);

    // Output decode for the current state/count; registered below, so the
    // bus lags the state register by exactly one cycle.
    always_comb begin
        inst_d       = IDLE_INST;
        core_reset_d = 1'b0;
        done_d       = 1'b0;
        j            = 32'(cnt) - 32'd1;
        case (state)
            S_RST: core_reset_d = 1'b1;
            S_W_L0: begin
                if (cnt < wr) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(w_addr_start + 32'(kij) * w_addr_offset + 32'(cnt));
                end
                // SRAM read latency of one cycle
                if (cnt != 16'd0) inst_d[2] = 1'b1;
            end
            S_W_LD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_A_L0: begin
                if (cnt < NIJ) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(cnt);
                end
                if (cnt != 16'd0) inst_d[2] = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_OF_RD: begin
                if (cnt < NIJ) inst_d[6] = 1'b1;
                if (cnt != 16'd0) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = 11'(32'(kij) * len_nij + j);
                end
            end
            S_ACC: begin
                // per output: reset, len_kij reads, acc trails reads by one, relu
                if (cnt == 16'd0) begin
                    core_reset_d = 1'b1;
                end else begin
                    if (cnt <= KIJ_CYC) begin
                        inst_d[32]    = 1'b0;
                        inst_d[30:20] = 11'((32'(o) / o_ni_dim) * a_pad_ni_dim + 32'(o) % o_ni_dim
                                            + (j / ki_dim) * a_pad_ni_dim + j % ki_dim + j * len_nij);
                    end
                    if (cnt >= 16'd2 && cnt <= ACC_LAST - 16'd1) inst_d[33] = 1'b1;
                    if (cnt == ACC_LAST) begin
                        inst_d[34] = 1'b1;
                        done_d     = (o == ONIJ_LAST);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            o          <= '0;
            kij        <= '0;
            mode_r     <= 1'b0;
            inst       <= IDLE_INST;
            core_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            kij_idx    <= '0;
        end else begin
            inst       <= inst_d;
            core_reset <= core_reset_d;
            done       <= done_d;
            busy       <= (state != S_IDLE);
            kij_idx    <= kij;
            case (state)
                S_IDLE: begin
                    // busy still covers the final output cycle, so gate on it too
                    if (start && !busy) begin
                        state  <= S_RST;
                        cnt    <= '0;
                        kij    <= '0;
                        o      <= '0;
                        mode_r <= mode;
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin state <= S_W_L0; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_W_L0: begin
                    if (cnt == wr) begin state <= S_W_LD; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_W_LD: begin
                    if (cnt == wr - 16'd1) begin state <= S_GAP; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin state <= S_A_L0; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_A_L0: begin
                    if (cnt == NIJ) begin state <= S_EXEC; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_EXEC: begin
                    if (cnt == NIJ_LAST) begin state <= S_DRAIN; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_DRAIN: begin
                    if (cnt == NIJ_LAST) begin state <= S_OF_RD; cnt <= '0; end
                    else cnt <= cnt + 16'd1;
                end
                S_OF_RD: begin
                    if (cnt == NIJ) begin
                        cnt <= '0;
                        if (kij == KIJ_LAST) begin
                            state <= S_ACC;
                            o     <= '0;
                        end else begin
                            state <= S_RST;
                            kij   <= kij + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ACC: begin
                    if (cnt == ACC_LAST) begin
                        cnt <= '0;
                        if (o == ONIJ_LAST) begin
                            state <= S_IDLE;
                            kij   <= '0;
                        end else begin
                            o <= o + 16'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_inst_seq.sv
// tb_conv_inst_seq: self-checking bench for conv_inst_seq. A reference model
// expands the pass description (phases, durations, address formulas) into an
// expected per-cycle trace; each task compares the DUT against it and against
// aggregate properties (pulse counts, address coverage, exclusivity).
module tb_conv_inst_seq;

    localparam int COL  = 8;
    localparam int NIJ  = 36;
    localparam int KIJ  = 9;
    localparam int ONIJ = 16;
    localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [34:0] inst;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    typedef struct {
        logic [34:0] inst;
        logic        cr;
        logic        dn;
        logic [3:0]  kij;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    conv_inst_seq #(
        .col(COL), .len_nij(NIJ), .len_kij(KIJ), .len_onij(ONIJ),
        .o_ni_dim(4), .a_pad_ni_dim(6), .ki_dim(3),
        .w_addr_start(1024), .w_addr_offset(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .inst(inst), .core_reset(core_reset), .busy(busy),
        .done(done), .kij_idx(kij_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [34:0] v, input logic cr, input logic dn, input int k);
        exp_t e;
        e.inst = v;
        e.cr   = cr;
        e.dn   = dn;
        e.kij  = 4'(k);
        exp_q.push_back(e);
    endtask

    // Expected cycle-by-cycle output of a whole pass, starting with the first
    // cycle after the start edge has been registered.
    task automatic build_trace(input logic m);
        int wr;
        logic [34:0] v;
        wr = m ? 2 * COL : COL;
        exp_q.delete();
        for (int k = 0; k < KIJ; k++) begin
            for (int n = 0; n < 11; n++) put(IDLE_INST, 1'b1, 1'b0, k);
            for (int n = 0; n <= wr; n++) begin
                v = IDLE_INST;
                if (n < wr) begin v[19] = 1'b0; v[17:7] = 11'(1024 + k * 16 + n); end
                if (n > 0) v[2] = 1'b1;
                put(v, 1'b0, 1'b0, k);
            end
            for (int n = 0; n < wr; n++) begin
                v = IDLE_INST; v[3] = 1'b1; v[0] = 1'b1;
                put(v, 1'b0, 1'b0, k);
            end
            for (int n = 0; n < 11; n++) put(IDLE_INST, 1'b0, 1'b0, k);
            for (int n = 0; n <= NIJ; n++) begin
                v = IDLE_INST;
                if (n < NIJ) begin v[19] = 1'b0; v[17:7] = 11'(n); end
                if (n > 0) v[2] = 1'b1;
                put(v, 1'b0, 1'b0, k);
            end
            for (int n = 0; n < NIJ; n++) begin
                v = IDLE_INST; v[3] = 1'b1; v[1] = 1'b1;
                put(v, 1'b0, 1'b0, k);
            end
            for (int n = 0; n < NIJ; n++) put(IDLE_INST, 1'b0, 1'b0, k);
            for (int n = 0; n <= NIJ; n++) begin
                v = IDLE_INST;
                if (n < NIJ) v[6] = 1'b1;
                if (n > 0) begin v[32] = 1'b0; v[31] = 1'b0; v[30:20] = 11'(k * NIJ + n - 1); end
                put(v, 1'b0, 1'b0, k);
            end
        end
        for (int o = 0; o < ONIJ; o++) begin
            put(IDLE_INST, 1'b1, 1'b0, KIJ - 1);
            for (int j = 0; j < KIJ; j++) begin
                v = IDLE_INST;
                v[32] = 1'b0;
                v[30:20] = 11'((o / 4) * 6 + o % 4 + (j / 3) * 6 + j % 3 + j * NIJ);
                if (j > 0) v[33] = 1'b1;
                put(v, 1'b0, 1'b0, KIJ - 1);
            end
            v = IDLE_INST; v[33] = 1'b1;
            put(v, 1'b0, 1'b0, KIJ - 1);
            v = IDLE_INST; v[34] = 1'b1;
            put(v, 1'b0, (o == ONIJ - 1), KIJ - 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (inst !== IDLE_INST || busy !== 1'b0 || done !== 1'b0 ||
                core_reset !== 1'b0 || kij_idx !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got inst=%h busy=%b done=%b cr=%b kij=%0d want inst=%h busy=0 done=0 cr=0 kij=0",
                         i, inst, busy, done, core_reset, kij_idx, IDLE_INST);
            end
        end
    endtask

    // One full pass in mode m; with toggle set, start and mode are randomised
    // every cycle while the pass runs and must have no effect.
    task automatic test_pass(input logic m, input bit toggle);
        int loads[16];
        int wr_hits[2048];
        int relu_n, done_n, done_relu, ofifo_n, rd_n, bad, wr_total, first_idx;
        logic done_with_relu, first_seen, k8_seen, l0wr_at_first, l0wr_next;
        logic [10:0] first_addr, k8_addr, a49;
        exp_t e;
        foreach (loads[i]) loads[i] = 0;
        foreach (wr_hits[i]) wr_hits[i] = 0;
        relu_n = 0; done_n = 0; done_relu = 0; ofifo_n = 0; rd_n = 0; first_idx = 0;
        done_with_relu = 1'b0; first_seen = 1'b0; k8_seen = 1'b0;
        l0wr_at_first = 1'b1; l0wr_next = 1'b0;
        first_addr = '0; k8_addr = '0; a49 = '0;
        build_trace(m);

        start = 1'b1; mode = m;
        step();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            e = exp_q[i];
            vectors++;
            if (inst !== e.inst || core_reset !== e.cr || done !== e.dn ||
                kij_idx !== e.kij || busy !== 1'b1) begin
                errors++;
                $display("FAIL trace[%0d] got inst=%h cr=%b done=%b kij=%0d busy=%b want inst=%h cr=%b done=%b kij=%0d busy=1",
                         i, inst, core_reset, done, kij_idx, busy, e.inst, e.cr, e.dn, e.kij);
            end
            vectors++;
            if ((inst[1] && inst[0]) || (inst[2] && inst[3])) begin
                errors++;
                $display("FAIL exclusive[%0d] got exec=%b load=%b l0_wr=%b l0_rd=%b want at most one of each pair",
                         i, inst[1], inst[0], inst[2], inst[3]);
            end
            if (inst[0]) loads[kij_idx]++;
            if (inst[6]) ofifo_n++;
            if (!inst[32] && !inst[31]) wr_hits[inst[30:20]]++;
            if (!inst[32] && inst[31]) begin
                if (rd_n == 5 * KIJ + 4) a49 = inst[30:20];
                rd_n++;
            end
            if (inst[34]) relu_n++;
            if (done) begin done_n++; done_relu = relu_n; done_with_relu = inst[34]; end
            if (first_seen && i == first_idx + 1) l0wr_next = inst[2];
            if (!first_seen && !inst[19]) begin
                first_seen = 1'b1; first_idx = i;
                first_addr = inst[17:7]; l0wr_at_first = inst[2];
            end
            if (!k8_seen && kij_idx == 4'd8 && !inst[19]) begin
                k8_seen = 1'b1; k8_addr = inst[17:7];
            end
            if (toggle) begin
                start = 1'($urandom_range(0, 1));
                mode  = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0; mode = 1'b0;

        for (int k = 0; k < KIJ; k++) begin
            vectors++;
            if (loads[k] != (m ? 16 : 8)) begin
                errors++;
                $display("FAIL load_count kij=%0d got %0d want %0d", k, loads[k], m ? 16 : 8);
            end
        end
        bad = 0; wr_total = 0;
        foreach (wr_hits[a]) begin
            wr_total += wr_hits[a];
            if (a < KIJ * NIJ && wr_hits[a] != 1) bad++;
        end
        vectors++;
        if (bad != 0 || wr_total != KIJ * NIJ) begin
            errors++;
            $display("FAIL pmem_writes got bad=%0d total=%0d want bad=0 total=%0d", bad, wr_total, KIJ * NIJ);
        end
        vectors++;
        if (ofifo_n != KIJ * NIJ) begin
            errors++;
            $display("FAIL ofifo_count got %0d want %0d", ofifo_n, KIJ * NIJ);
        end
        vectors++;
        if (a49 !== 11'd158) begin
            errors++;
            $display("FAIL acc_addr_o5_j4 got %0d want 158", a49);
        end
        vectors++;
        if (relu_n != ONIJ || done_n != 1 || done_relu != ONIJ || done_with_relu !== 1'b1) begin
            errors++;
            $display("FAIL relu_done got relu=%0d done=%0d done_at_relu=%0d with_relu=%b want 16 1 16 1",
                     relu_n, done_n, done_relu, done_with_relu);
        end
        vectors++;
        if (first_addr !== 11'd1024 || k8_addr !== 11'd1152 || l0wr_at_first !== 1'b0 || l0wr_next !== 1'b1) begin
            errors++;
            $display("FAIL weight_addr got first=%0d k8=%0d l0wr@first=%b l0wr@next=%b want 1024 1152 0 1",
                     first_addr, k8_addr, l0wr_at_first, l0wr_next);
        end
        step();
        vectors++;
        if (inst !== IDLE_INST || busy !== 1'b0 || done !== 1'b0 || kij_idx !== 4'd0) begin
            errors++;
            $display("FAIL post_pass got inst=%h busy=%b done=%b kij=%0d want inst=%h busy=0 done=0 kij=0",
                     inst, busy, done, kij_idx, IDLE_INST);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        start = 1'b1; mode = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (kij_idx == 4'd3 && inst[1]) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL reach_exec_kij3 got timeout want execute at kij=3");
        end
        reset = 1'b1;
        step();
        vectors++;
        if (inst !== IDLE_INST || busy !== 1'b0 || done !== 1'b0 ||
            core_reset !== 1'b0 || kij_idx !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got inst=%h busy=%b done=%b cr=%b kij=%0d want inst=%h 0 0 0 0",
                     inst, busy, done, core_reset, kij_idx, IDLE_INST);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (inst !== IDLE_INST || busy !== 1'b0 || core_reset !== 1'b0) begin
                errors++;
                $display("FAIL after_reset[%0d] got inst=%h busy=%b cr=%b want inst=%h busy=0 cr=0",
                         i, inst, busy, core_reset, IDLE_INST);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        test_reset();
        test_pass(1'b1, 1'b0);
        test_pass(1'b0, 1'b0);
        test_reset_mid();
        test_pass(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < int'($urandom_range(1, 5)); i++) step();
        test_pass(1'b1, 1'b1);
        test_pass(1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
